// File: rtl/pipe_mem_unit.sv
// pipe_mem_unit: word memory with a fixed-latency read pipeline and a credit-limited response FIFO.
// Optional feature macro MEM_ALIGN_CHECK_EN: adds resp_err, flags misaligned reads, drops misaligned writes.
module pipe_mem_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WORDS_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              resp_err
`endif
);

  localparam int unsigned MEM_WORDS = 1 << WORDS_LOG2;
  localparam int unsigned PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(RESP_DEPTH + 1);
  localparam int unsigned SUM_W     = CNT_W + 1;

  logic [DATA_W-1:0]     mem       [MEM_WORDS];
  logic [DATA_W-1:0]     pipe_data [LATENCY];
  logic [DATA_W-1:0]     fifo_data [RESP_DEPTH];
  logic [LATENCY-1:0]    pipe_vld, pipe_vld_n;
  logic [PTR_W-1:0]      wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0]      inflight, inflight_n, fifo_count, fifo_count_n;
  logic                  req_ready_n, resp_valid_n;
  logic [DATA_W-1:0]     resp_data_n, rd_word;
  logic [WORDS_LOG2-1:0] idx;
  logic                  accept, rd_accept, wr_en, push, pop, head_from_pipe;
  logic                  unused_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Word index only; high bits alias and byte-offset bits select nothing.
  assign idx         = req_addr[WORDS_LOG2+1:2];
  assign unused_addr = ^{req_addr[ADDR_W-1:WORDS_LOG2+2], req_addr[1:0]};

  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_op;
  assign push      = pipe_vld[LATENCY-1];
  assign pop       = resp_valid & resp_ready;
  // FIFO holds nothing besides the popped head: the new head is the word exiting the pipeline.
  assign head_from_pipe = (fifo_count - CNT_W'(pop)) == '0;

`ifdef MEM_ALIGN_CHECK_EN
  logic                  misaligned;
  logic [LATENCY-1:0]    pipe_err;
  logic [RESP_DEPTH-1:0] fifo_err;
  logic                  resp_err_n;

  assign misaligned = (req_addr[1:0] != 2'b00);
  assign wr_en      = accept & req_op & ~misaligned;
  assign rd_word    = misaligned ? '0 : mem[idx];
`else
  assign wr_en      = accept & req_op;
  assign rd_word    = mem[idx];
`endif

  // Next-state for counters, pointers and the registered response head.
  always_comb begin
    pipe_vld_n    = '0;
    pipe_vld_n[0] = rd_accept;
    for (int i = 1; i < LATENCY; i++) pipe_vld_n[i] = pipe_vld[i-1];
    inflight_n   = inflight + CNT_W'(rd_accept) - CNT_W'(push);
    fifo_count_n = fifo_count + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_n     = push ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_n     = pop ? ptr_inc(rd_ptr) : rd_ptr;
    req_ready_n  = (SUM_W'(inflight_n) + SUM_W'(fifo_count_n)) < SUM_W'(RESP_DEPTH);
    resp_valid_n = (fifo_count_n != '0);
    resp_data_n  = resp_data;
    if (resp_valid_n) resp_data_n = head_from_pipe ? pipe_data[LATENCY-1] : fifo_data[rd_ptr_n];
`ifdef MEM_ALIGN_CHECK_EN
    resp_err_n = resp_err;
    if (resp_valid_n) resp_err_n = head_from_pipe ? pipe_err[LATENCY-1] : fifo_err[rd_ptr_n];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld   <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      pipe_vld   <= pipe_vld_n;
      inflight   <= inflight_n;
      fifo_count <= fifo_count_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_data  <= resp_data_n;
`ifdef MEM_ALIGN_CHECK_EN
      resp_err   <= resp_err_n;
`endif
    end
  end

  // Array, read pipeline and FIFO storage carry no reset; validity lives in the control above.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[idx] <= req_wdata;
    if (rd_accept) pipe_data[0] <= rd_word;
    for (int i = 1; i < LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
    if (push) fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rd_accept) pipe_err[0] <= misaligned;
    for (int i = 1; i < LATENCY; i++) pipe_err[i] <= pipe_err[i-1];
    if (push) fifo_err[wr_ptr] <= pipe_err[LATENCY-1];
  end
`endif

endmodule
